// File: rtl/fp_mult_pkg.sv
// rtl/fp_mult_pkg.sv - fixed-point multiplier defaults, types and Q8.24 constants
package fp_mult_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 32;
    localparam int DEFAULT_FRACTIONAL_BITS = 24;
    localparam int DEFAULT_INTEGER_BITS    = DEFAULT_DATA_WIDTH - DEFAULT_FRACTIONAL_BITS;
    localparam int STATS_W                 = 16;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] fixed_t;

    localparam fixed_t FIX_ZERO    = 32'h0000_0000;
    localparam fixed_t FIX_ONE     = 32'h0100_0000;
    localparam fixed_t FIX_HALF    = 32'h0080_0000;
    localparam fixed_t FIX_NEG_ONE = 32'hFF00_0000;

endpackage

// File: rtl/fp_mult.sv
// rtl/fp_mult.sv - signed fixed-point multiply, truncating, wrapping on overflow
module fp_mult #(
    parameter int DATA_WIDTH      = 32,
    parameter int FRACTIONAL_BITS = 24
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] p
);

    logic signed [2*DATA_WIDTH-1:0] full;
    logic                           unused_bits;

    assign full = a * b;
    // Dropping the low fractional bits truncates toward -inf; the top bits simply wrap.
    assign p           = full[DATA_WIDTH+FRACTIONAL_BITS-1:FRACTIONAL_BITS];
    assign unused_bits = ^{full[2*DATA_WIDTH-1:DATA_WIDTH+FRACTIONAL_BITS], full[FRACTIONAL_BITS-1:0]};

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with internal rotating priority pointer
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W-1:0] rr_ptr;
    logic            found;
    int              j;

    // Scan from rr_ptr upward, wrapping, and take the first active request.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (enable && !found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// rtl/fp_mult_arbiter.sv - round-robin shared fixed-point multiplier, optional FP_MULT_ARB_STATS_EN counters
module fp_mult_arbiter
    import fp_mult_pkg::*;
#(
    parameter  int NUM_REQ         = 4,
    parameter  int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter  int FRACTIONAL_BITS = DEFAULT_FRACTIONAL_BITS,
    localparam int ID_W            = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data
`ifdef FP_MULT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STATS_W-1:0]    grant_count
`endif
);

    logic                         s1_valid;
    logic signed [DATA_WIDTH-1:0] s1_a;
    logic signed [DATA_WIDTH-1:0] s1_b;
    logic [ID_W-1:0]              s1_id;
    logic                         s2_valid;
    logic [DATA_WIDTH-1:0]        s2_data;
    logic [ID_W-1:0]              s2_id;

    logic                         s1_adv;
    logic                         s2_adv;
    logic                         arb_enable;
    logic [NUM_REQ-1:0]           grant;
    logic [ID_W-1:0]              grant_idx;
    logic signed [DATA_WIDTH-1:0] a_sel;
    logic signed [DATA_WIDTH-1:0] b_sel;
    logic signed [DATA_WIDTH-1:0] product;

    assign s2_adv     = !s2_valid || rsp_ready;
    assign s1_adv     = !s1_valid || s2_adv;
    // Holding the arbiter off during reset keeps req_ready low so nothing is accepted.
    assign arb_enable = s1_adv && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .enable (arb_enable),
        .grant  (grant),
        .idx    (grant_idx)
    );

    assign req_ready = grant;

    // One-hot grant lets the operand mux be a plain AND-OR.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = a_sel | req_a[i*DATA_WIDTH +: DATA_WIDTH];
                b_sel = b_sel | req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else if (s1_adv) begin
            s1_valid <= |grant;
            s1_a     <= a_sel;
            s1_b     <= b_sel;
            s1_id    <= grant_idx;
        end
    end

    fp_mult #(
        .DATA_WIDTH      (DATA_WIDTH),
        .FRACTIONAL_BITS (FRACTIONAL_BITS)
    ) u_mult (
        .a (s1_a),
        .b (s1_b),
        .p (product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            s2_data  <= product;
            s2_id    <= s1_id;
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_data  = s2_data;
    assign rsp_id    = s2_id;

`ifdef FP_MULT_ARB_STATS_EN
    logic [STATS_W-1:0] count_q [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset) begin
                count_q[i] <= '0;
            end else if (grant[i] && (count_q[i] != {STATS_W{1'b1}})) begin
                count_q[i] <= count_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_count[i*STATS_W +: STATS_W] = count_q[i];
        end
    end
`else
`endif

endmodule
